// File: rtl/cart_billing_if.sv
// cart_billing_if
// Groups the cart billing handshake into one bundle.
//   master : drives item, checkout, payment and cancel requests; observes results
//   slave  : the billing block; consumes requests and drives total, item_count,
//            amount_due, change, state, bill_done and err
interface cart_billing_if #(
    parameter int TOTAL_W = 16
);
    logic               item_valid;
    logic               item_remove;
    logic [9:0]         item_cost;
    logic               checkout_req;
    logic               pay_valid;
    logic [TOTAL_W-1:0] pay_amount;
    logic               cancel;

    logic [TOTAL_W-1:0] total;
    logic [7:0]         item_count;
    logic [TOTAL_W-1:0] amount_due;
    logic [TOTAL_W-1:0] change;
    logic [2:0]         state;
    logic               bill_done;
    logic               err;

    modport master (
        output item_valid, item_remove, item_cost, checkout_req,
               pay_valid, pay_amount, cancel,
        input  total, item_count, amount_due, change, state, bill_done, err
    );

    modport slave (
        input  item_valid, item_remove, item_cost, checkout_req,
               pay_valid, pay_amount, cancel,
        output total, item_count, amount_due, change, state, bill_done, err
    );
endinterface

// File: rtl/cart_billing.sv
// cart_billing
// Keeps a shopping cart's running total and item count, computes the amount
// due at checkout, accumulates payment tenders and reports change.
// Ports:
//   clk   : system clock, rising edge
//   reset : asynchronous active-low reset
//   bus   : cart_billing_if.slave (item/checkout/payment/cancel requests in,
//           total/item_count/amount_due/change/state/bill_done/err out)
// Optional feature: define CART_DISCOUNT_EN to apply a 12.5% discount to
// carts whose total is at least DISC_THRESH.
module cart_billing #(
    parameter int MAX_ITEMS   = 255,
    parameter int TOTAL_W     = 16,
    parameter int DISC_THRESH = 1000
) (
    input  logic           clk,
    input  logic           reset,
    cart_billing_if.slave  bus
);
    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] SHOP = 3'd1;
    localparam logic [2:0] BILL = 3'd2;
    localparam logic [2:0] PAY  = 3'd3;
    localparam logic [2:0] DONE = 3'd4;

    logic [2:0]         state_q;
    logic [TOTAL_W-1:0] total_q;
    logic [TOTAL_W-1:0] due_q;
    logic [TOTAL_W-1:0] change_q;
    logic [7:0]         count_q;
    logic [TOTAL_W:0]   paid_q;
    logic               done_q;
    logic               err_q;

    logic               add_ok;
    logic               rem_ok;
    logic [TOTAL_W-1:0] cost_ext;
    logic [TOTAL_W:0]   add_sum;
    logic               add_fits;
    logic               rem_fits;
    logic [TOTAL_W+1:0] pay_sum;
    logic [TOTAL_W:0]   paid_next;
    logic [TOTAL_W:0]   change_full;
    logic [TOTAL_W-1:0] bill_due;

    always_comb begin
        cost_ext = TOTAL_W'(bus.item_cost);
        // A zero cost is an unreadable barcode and is dropped silently
        add_ok   = bus.item_valid  && (bus.item_cost != 10'd0);
        rem_ok   = bus.item_remove && (bus.item_cost != 10'd0);
        add_sum  = {1'b0, total_q} + {1'b0, cost_ext};
        add_fits = !add_sum[TOTAL_W] && (count_q != 8'(MAX_ITEMS));
        rem_fits = (total_q >= cost_ext) && (count_q != 8'd0);
        // Extra headroom bit lets the tender sum saturate instead of wrapping
        pay_sum     = {1'b0, paid_q} + (TOTAL_W+2)'(bus.pay_amount);
        paid_next   = pay_sum[TOTAL_W+1] ? '1 : pay_sum[TOTAL_W:0];
        change_full = paid_next - {1'b0, due_q};
`ifdef CART_DISCOUNT_EN
        if (total_q >= TOTAL_W'(DISC_THRESH))
            bill_due = total_q - (total_q >> 3);
        else
            bill_due = total_q;
`else
        bill_due = total_q;
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            total_q  <= '0;
            due_q    <= '0;
            change_q <= '0;
            count_q  <= '0;
            paid_q   <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            if (bus.cancel) begin
                state_q  <= IDLE;
                total_q  <= '0;
                due_q    <= '0;
                change_q <= '0;
                count_q  <= '0;
                paid_q   <= '0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (add_ok) begin
                            total_q <= cost_ext;
                            count_q <= 8'd1;
                            state_q <= SHOP;
                        end
                    end
                    SHOP: begin
                        if (add_ok) begin
                            if (add_fits) begin
                                total_q <= add_sum[TOTAL_W-1:0];
                                count_q <= count_q + 8'd1;
                            end
                            // A simultaneous remove is dropped and flagged
                            err_q <= !add_fits || rem_ok;
                            if (bus.checkout_req)
                                state_q <= BILL;
                        end else if (rem_ok) begin
                            if (rem_fits) begin
                                if (count_q == 8'd1) begin
                                    total_q <= '0;
                                    count_q <= 8'd0;
                                    state_q <= IDLE;
                                end else begin
                                    total_q <= total_q - cost_ext;
                                    count_q <= count_q - 8'd1;
                                    if (bus.checkout_req)
                                        state_q <= BILL;
                                end
                            end else begin
                                err_q <= 1'b1;
                                if (bus.checkout_req)
                                    state_q <= BILL;
                            end
                        end else if (bus.checkout_req && count_q != 8'd0) begin
                            state_q <= BILL;
                        end
                    end
                    BILL: begin
                        due_q   <= bill_due;
                        paid_q  <= '0;
                        state_q <= PAY;
                    end
                    PAY: begin
                        if (add_ok || rem_ok)
                            err_q <= 1'b1;
                        if (bus.pay_valid) begin
                            paid_q <= paid_next;
                            if (paid_next >= {1'b0, due_q}) begin
                                change_q <= change_full[TOTAL_W-1:0];
                                done_q   <= 1'b1;
                                state_q  <= DONE;
                            end
                        end
                    end
                    DONE: begin
                        if (add_ok) begin
                            change_q <= '0;
                            due_q    <= '0;
                            total_q  <= cost_ext;
                            count_q  <= 8'd1;
                            state_q  <= SHOP;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign bus.total      = total_q;
    assign bus.item_count = count_q;
    assign bus.amount_due = due_q;
    assign bus.change     = change_q;
    assign bus.state      = state_q;
    assign bus.bill_done  = done_q;
    assign bus.err        = err_q;
endmodule

// File: tb/tb_cart_billing.sv
// tb_cart_billing
// Directed-vector bench for cart_billing with hand-computed expectations.
module tb_cart_billing;
    logic clk;
    logic reset;
    int   errors;
    int   checks;

    cart_billing_if #(.TOTAL_W(16)) bus ();

    cart_billing #(
        .MAX_ITEMS  (255),
        .TOTAL_W    (16),
        .DISC_THRESH(1000)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic add_item(input logic [9:0] cost, input logic with_checkout);
        bus.item_valid   = 1'b1;
        bus.item_cost    = cost;
        bus.checkout_req = with_checkout;
        tick();
        bus.item_valid   = 1'b0;
        bus.item_cost    = 10'd0;
        bus.checkout_req = 1'b0;
    endtask

    task automatic remove_item(input logic [9:0] cost);
        bus.item_remove = 1'b1;
        bus.item_cost   = cost;
        tick();
        bus.item_remove = 1'b0;
        bus.item_cost   = 10'd0;
    endtask

    task automatic pay(input logic [15:0] amount);
        bus.pay_valid  = 1'b1;
        bus.pay_amount = amount;
        tick();
        bus.pay_valid  = 1'b0;
        bus.pay_amount = 16'd0;
    endtask

    task automatic checkout();
        bus.checkout_req = 1'b1;
        tick();
        bus.checkout_req = 1'b0;
    endtask

    task automatic do_cancel();
        bus.cancel = 1'b1;
        tick();
        bus.cancel = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        tick();
        checks++; if (bus.state !== 3'd0) begin errors++; $display("[TB] FAIL reset_state got=%0d exp=0", bus.state); end
        checks++; if (bus.total !== 16'd0) begin errors++; $display("[TB] FAIL reset_total got=%0d exp=0", bus.total); end
        checks++; if (bus.item_count !== 8'd0) begin errors++; $display("[TB] FAIL reset_count got=%0d exp=0", bus.item_count); end
        checks++; if (bus.amount_due !== 16'd0 || bus.change !== 16'd0) begin errors++; $display("[TB] FAIL reset_due_change got=%0d/%0d exp=0/0", bus.amount_due, bus.change); end
        checks++; if (bus.bill_done !== 1'b0 || bus.err !== 1'b0) begin errors++; $display("[TB] FAIL reset_pulses got=%b/%b exp=0/0", bus.bill_done, bus.err); end
        #2 reset = 1'b1;
        tick();
    endtask

    task automatic test_basic_bill();
        add_item(10'd240, 1'b0);
        checks++; if (bus.state !== 3'd1) begin errors++; $display("[TB] FAIL add240_state got=%0d exp=1", bus.state); end
        checks++; if (bus.total !== 16'd240) begin errors++; $display("[TB] FAIL add240_total got=%0d exp=240", bus.total); end
        add_item(10'd85, 1'b0);
        add_item(10'd0, 1'b0);
        checks++; if (bus.err !== 1'b0) begin errors++; $display("[TB] FAIL zero_cost_err got=%b exp=0", bus.err); end
        checks++; if (bus.item_count !== 8'd2 || bus.total !== 16'd325) begin errors++; $display("[TB] FAIL zero_cost_ignored got=%0d/%0d exp=2/325", bus.item_count, bus.total); end
        add_item(10'd300, 1'b0);
        checkout();
        checks++; if (bus.state !== 3'd2) begin errors++; $display("[TB] FAIL bill_state got=%0d exp=2", bus.state); end
        tick();
        checks++; if (bus.state !== 3'd3) begin errors++; $display("[TB] FAIL pay_state got=%0d exp=3", bus.state); end
        checks++; if (bus.amount_due !== 16'd625) begin errors++; $display("[TB] FAIL amount_due got=%0d exp=625", bus.amount_due); end
        checks++; if (bus.total !== 16'd625 || bus.item_count !== 8'd3) begin errors++; $display("[TB] FAIL cart_totals got=%0d/%0d exp=625/3", bus.total, bus.item_count); end
        pay(16'd500);
        checks++; if (bus.state !== 3'd3 || bus.bill_done !== 1'b0) begin errors++; $display("[TB] FAIL partial_pay got=%0d/%b exp=3/0", bus.state, bus.bill_done); end
        add_item(10'd50, 1'b0);
        checks++; if (bus.err !== 1'b1 || bus.total !== 16'd625) begin errors++; $display("[TB] FAIL item_in_pay got=%b/%0d exp=1/625", bus.err, bus.total); end
        pay(16'd200);
        checks++; if (bus.state !== 3'd4) begin errors++; $display("[TB] FAIL done_state got=%0d exp=4", bus.state); end
        checks++; if (bus.change !== 16'd75) begin errors++; $display("[TB] FAIL change got=%0d exp=75", bus.change); end
        checks++; if (bus.bill_done !== 1'b1) begin errors++; $display("[TB] FAIL bill_done_rise got=%b exp=1", bus.bill_done); end
        tick();
        checks++; if (bus.bill_done !== 1'b0) begin errors++; $display("[TB] FAIL bill_done_pulse got=%b exp=0", bus.bill_done); end
        checks++; if (bus.change !== 16'd75 || bus.total !== 16'd625) begin errors++; $display("[TB] FAIL done_hold got=%0d/%0d exp=75/625", bus.change, bus.total); end
    endtask

    task automatic test_remove();
        add_item(10'd100, 1'b0);
        checks++; if (bus.state !== 3'd1 || bus.total !== 16'd100 || bus.item_count !== 8'd1) begin errors++; $display("[TB] FAIL new_cart got=%0d/%0d/%0d exp=1/100/1", bus.state, bus.total, bus.item_count); end
        checks++; if (bus.amount_due !== 16'd0 || bus.change !== 16'd0) begin errors++; $display("[TB] FAIL new_cart_clear got=%0d/%0d exp=0/0", bus.amount_due, bus.change); end
        remove_item(10'd150);
        checks++; if (bus.err !== 1'b1 || bus.total !== 16'd100) begin errors++; $display("[TB] FAIL remove_too_big got=%b/%0d exp=1/100", bus.err, bus.total); end
        tick();
        checks++; if (bus.err !== 1'b0) begin errors++; $display("[TB] FAIL err_pulse got=%b exp=0", bus.err); end
        remove_item(10'd100);
        checks++; if (bus.state !== 3'd0 || bus.total !== 16'd0 || bus.item_count !== 8'd0) begin errors++; $display("[TB] FAIL remove_to_idle got=%0d/%0d/%0d exp=0/0/0", bus.state, bus.total, bus.item_count); end
    endtask

    task automatic test_same_cycle();
        add_item(10'd40, 1'b0);
        bus.item_valid  = 1'b1;
        bus.item_remove = 1'b1;
        bus.item_cost   = 10'd5;
        tick();
        bus.item_valid  = 1'b0;
        bus.item_remove = 1'b0;
        checks++; if (bus.total !== 16'd45 || bus.item_count !== 8'd2 || bus.err !== 1'b1) begin errors++; $display("[TB] FAIL add_remove_same got=%0d/%0d/%b exp=45/2/1", bus.total, bus.item_count, bus.err); end
        bus.cancel     = 1'b1;
        bus.item_valid = 1'b1;
        bus.item_cost  = 10'd7;
        tick();
        bus.cancel     = 1'b0;
        bus.item_valid = 1'b0;
        bus.item_cost  = 10'd0;
        checks++; if (bus.state !== 3'd0 || bus.total !== 16'd0 || bus.item_count !== 8'd0) begin errors++; $display("[TB] FAIL cancel_priority got=%0d/%0d/%0d exp=0/0/0", bus.state, bus.total, bus.item_count); end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 64; i++) add_item(10'd1023, 1'b0);
        add_item(10'd28, 1'b0);
        checks++; if (bus.total !== 16'd65500 || bus.item_count !== 8'd65) begin errors++; $display("[TB] FAIL fill_65500 got=%0d/%0d exp=65500/65", bus.total, bus.item_count); end
        add_item(10'd100, 1'b0);
        checks++; if (bus.err !== 1'b1 || bus.total !== 16'd65500 || bus.item_count !== 8'd65) begin errors++; $display("[TB] FAIL overflow_reject got=%b/%0d/%0d exp=1/65500/65", bus.err, bus.total, bus.item_count); end
        add_item(10'd35, 1'b0);
        checks++; if (bus.err !== 1'b0 || bus.total !== 16'd65535) begin errors++; $display("[TB] FAIL exact_max_total got=%b/%0d exp=0/65535", bus.err, bus.total); end
        do_cancel();
    endtask

    task automatic test_max_items();
        for (int i = 0; i < 255; i++) add_item(10'd1, 1'b0);
        checks++; if (bus.item_count !== 8'd255 || bus.total !== 16'd255 || bus.err !== 1'b0) begin errors++; $display("[TB] FAIL fill_255 got=%0d/%0d/%b exp=255/255/0", bus.item_count, bus.total, bus.err); end
        add_item(10'd1, 1'b0);
        checks++; if (bus.err !== 1'b1 || bus.item_count !== 8'd255 || bus.total !== 16'd255) begin errors++; $display("[TB] FAIL item_limit got=%b/%0d/%0d exp=1/255/255", bus.err, bus.item_count, bus.total); end
        do_cancel();
    endtask

    task automatic test_checkout_with_add();
        add_item(10'd10, 1'b0);
        add_item(10'd20, 1'b1);
        checks++; if (bus.state !== 3'd2 || bus.total !== 16'd30 || bus.item_count !== 8'd2) begin errors++; $display("[TB] FAIL add_with_checkout got=%0d/%0d/%0d exp=2/30/2", bus.state, bus.total, bus.item_count); end
        tick();
        checks++; if (bus.state !== 3'd3 || bus.amount_due !== 16'd30) begin errors++; $display("[TB] FAIL due_with_add got=%0d/%0d exp=3/30", bus.state, bus.amount_due); end
        do_cancel();
        checks++; if (bus.state !== 3'd0 || bus.total !== 16'd0 || bus.amount_due !== 16'd0 || bus.item_count !== 8'd0) begin errors++; $display("[TB] FAIL cancel_in_pay got=%0d/%0d/%0d/%0d exp=0/0/0/0", bus.state, bus.total, bus.amount_due, bus.item_count); end
    endtask

    task automatic test_async_reset();
        add_item(10'd50, 1'b0);
        checkout();
        tick();
        checks++; if (bus.state !== 3'd3) begin errors++; $display("[TB] FAIL pre_reset_pay got=%0d exp=3", bus.state); end
        #2 reset = 1'b0;
        #1;
        checks++; if (bus.state !== 3'd0 || bus.total !== 16'd0 || bus.item_count !== 8'd0 || bus.amount_due !== 16'd0) begin errors++; $display("[TB] FAIL async_reset got=%0d/%0d/%0d/%0d exp=0/0/0/0", bus.state, bus.total, bus.item_count, bus.amount_due); end
        #2 reset = 1'b1;
        tick();
        checks++; if (bus.state !== 3'd0) begin errors++; $display("[TB] FAIL post_reset_idle got=%0d exp=0", bus.state); end
    endtask

    task automatic test_discount();
        add_item(10'd1000, 1'b0);
        add_item(10'd200, 1'b1);
        tick();
`ifdef CART_DISCOUNT_EN
        checks++; if (bus.amount_due !== 16'd1050) begin errors++; $display("[TB] FAIL discount_1200 got=%0d exp=1050", bus.amount_due); end
`else
        checks++; if (bus.amount_due !== 16'd1200) begin errors++; $display("[TB] FAIL nodiscount_1200 got=%0d exp=1200", bus.amount_due); end
`endif
        do_cancel();
        add_item(10'd999, 1'b0);
        checkout();
        tick();
        checks++; if (bus.amount_due !== 16'd999) begin errors++; $display("[TB] FAIL below_thresh_999 got=%0d exp=999", bus.amount_due); end
        do_cancel();
    endtask

    initial begin
        errors           = 0;
        checks           = 0;
        reset            = 1'b0;
        bus.item_valid   = 1'b0;
        bus.item_remove  = 1'b0;
        bus.item_cost    = 10'd0;
        bus.checkout_req = 1'b0;
        bus.pay_valid    = 1'b0;
        bus.pay_amount   = 16'd0;
        bus.cancel       = 1'b0;

        test_reset();
        test_basic_bill();
        test_remove();
        test_same_cycle();
        test_overflow();
        test_max_items();
        test_checkout_with_add();
        test_async_reset();
        test_discount();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
